// File: rtl/m_digit_scanner_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// scan FSM states, active-low segment patterns and a counter-width helper.
package pkg_digit_scanner;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } e_scan_state;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int f_pos(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_digit_scanner_seg7_decoder.sv
// Combinational hex-to-7-segment decoder; values outside the counter base
// render as a dash.
module m_seg7_decoder
    import pkg_digit_scanner::*;
(
    input  logic [3:0] value,
    input  logic [4:0] base,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if ({1'b0, value} < base) begin
            case (value)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/m_digit_scanner.sv
// Time-multiplexed common-anode display driver: per-frame digit snapshot,
// blank gap between digits, leading-zero suppression, sticky overflow on dp.
module m_digit_scanner
    import pkg_digit_scanner::*;
#(
    parameter int P_DIGITS      = 4,
    parameter int P_SCAN_DIVIDE = 1000,
    parameter int P_BASE_NUMBER = 10
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [4*P_DIGITS-1:0]   digits,
    input  logic [P_DIGITS-1:0]     dp_in,
    input  logic                    c_in,
    input  logic                    clr,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [P_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int IDX_W = f_pos(P_DIGITS);
    localparam int PRE_W = f_pos(P_SCAN_DIVIDE);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(P_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_FIRST = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(P_SCAN_DIVIDE - 1);
    localparam logic [4:0]       BASE      = 5'(P_BASE_NUMBER);

    e_scan_state               state;
    logic [IDX_W-1:0]          idx;
    logic [PRE_W-1:0]          presc;
    logic [4*P_DIGITS-1:0]     snap_digits;
    logic [P_DIGITS-1:0]       snap_dp;
    logic                      ovf;

    logic [P_DIGITS-1:0]       blank_mask;
    logic [P_DIGITS-1:0]       an_show;
    logic [3:0]                cur_digit;
    logic                      cur_blank;
    logic                      cur_dp_req;
    logic [6:0]                cur_seg;

    // A digit is suppressed when it and every more significant digit are zero.
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        blank_mask  = '0;
        for (int i = P_DIGITS - 1; i >= 0; i--) begin
            zeros_above   = zeros_above & (snap_digits[4*i +: 4] == 4'h0);
            blank_mask[i] = zeros_above && (i != 0);
        end
    end

    always_comb begin
        cur_digit  = 4'h0;
        cur_blank  = 1'b0;
        cur_dp_req = 1'b0;
        an_show    = '1;
        for (int i = 0; i < P_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit  = snap_digits[4*i +: 4];
                cur_blank  = blank_mask[i];
                cur_dp_req = snap_dp[i];
                an_show[i] = 1'b0;
            end
        end
    end

    m_seg7_decoder u_decoder (
        .value (cur_digit),
        .base  (BASE),
        .seg   (cur_seg)
    );

    // state/idx/presc describe the slot whose outputs are registered on this
    // edge, so the pins show that slot during the following cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_BLANK;
            idx         <= '0;
            presc       <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            ovf         <= 1'b0;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            an          <= '1;
            frame_tick  <= 1'b0;
        end else begin
            if (c_in)
                ovf <= 1'b1;
            else if (clr)
                ovf <= 1'b0;

            case (state)
                S_BLANK: begin
                    an         <= '1;
                    seg        <= SEG_OFF;
                    dp         <= 1'b1;
                    frame_tick <= (idx == '0);
                    if (idx == '0) begin
                        snap_digits <= digits;
                        snap_dp     <= dp_in;
                    end
                    presc <= PRE_FIRST;
                    state <= S_SHOW;
                end
                S_SHOW: begin
                    an         <= an_show;
                    frame_tick <= 1'b0;
                    if (presc == PRE_FIRST) begin
                        seg <= cur_blank ? SEG_OFF : cur_seg;
                        dp  <= ovf ? 1'b0 : (cur_blank | ~cur_dp_req);
                    end
                    if (presc == PRE_LAST) begin
                        state <= S_BLANK;
                        presc <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_digit_scanner.sv
// Scoreboard bench for m_digit_scanner (4 digits, 4-cycle slots), with a
// second instance at base 16 for the out-of-base dash case.
module tb_m_digit_scanner;

    localparam int D = 4;
    localparam int P = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        logic [6:0] seg16;
    } obs_t;

    localparam obs_t RST_VAL = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, seg16: 7'h7F};
    localparam logic [6:0] TB_SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        c_in = 1'b0;
    logic        clr = 1'b0;
    logic [6:0]  seg, seg16;
    logic        dp, dp16, frame_tick, ft16;
    logic [3:0]  an, an16;

    int    total = 0;
    int    bad = 0;
    string phase = "reset";
    obs_t  exp_q[$];

    always #5 clk = ~clk;

    m_digit_scanner #(.P_DIGITS(D), .P_SCAN_DIVIDE(P), .P_BASE_NUMBER(10)) dut (
        .clk(clk), .n_reset(n_reset), .digits(digits), .dp_in(dp_in), .c_in(c_in), .clr(clr),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

    m_digit_scanner #(.P_DIGITS(D), .P_SCAN_DIVIDE(P), .P_BASE_NUMBER(16)) dut16 (
        .clk(clk), .n_reset(n_reset), .digits(digits), .dp_in(dp_in), .c_in(c_in), .clr(clr),
        .seg(seg16), .dp(dp16), .an(an16), .frame_tick(ft16));

    function automatic logic [6:0] dec(input logic [3:0] v, input int base);
        if (int'(v) >= base) return 7'h3F;
        return TB_SEG[v];
    endfunction

    task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference model: slot position and digit derived from cycles since reset.
    int          k, m_p, m_id;
    logic [15:0] m_snap;
    logic [3:0]  m_dpin;
    logic        m_ovf, m_blank, h_dp;
    logic [6:0]  h_seg, h_seg16;
    logic [3:0]  m_dv;
    obs_t        m_e;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            k = 0; m_snap = '0; m_dpin = '0; m_ovf = 1'b0;
            h_seg = 7'h7F; h_seg16 = 7'h7F; h_dp = 1'b1;
            exp_q.delete();
        end else begin
            m_p  = k % P;
            m_id = (k / P) % D;
            if (m_p == 0) begin
                if (m_id == 0) begin
                    m_snap = digits;
                    m_dpin = dp_in;
                end
                m_e = RST_VAL;
                m_e.ft = (m_id == 0);
            end else begin
                if (m_p == 1) begin
                    m_blank = (m_id > 0) && ((m_snap >> (4 * m_id)) == 16'h0);
                    m_dv    = m_snap[4*m_id +: 4];
                    h_seg   = m_blank ? 7'h7F : dec(m_dv, 10);
                    h_seg16 = m_blank ? 7'h7F : dec(m_dv, 16);
                    h_dp    = m_ovf ? 1'b0 : (m_blank ? 1'b1 : !m_dpin[m_id]);
                end
                m_e.an    = ~(4'b0001 << m_id);
                m_e.seg   = h_seg;
                m_e.dp    = h_dp;
                m_e.ft    = 1'b0;
                m_e.seg16 = h_seg16;
            end
            exp_q.push_back(m_e);
            if (c_in) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            k++;
        end
    end

    obs_t mon_o, mon_e;

    always @(negedge clk) begin
        mon_o = '{an: an, seg: seg, dp: dp, ft: frame_tick, seg16: seg16};
        if (!n_reset) begin
            chk("reset_outputs", mon_o, RST_VAL);
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(phase, mon_o, mon_e);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        run(3);
        phase = "count_1234";
        digits = 16'h1234;
        n_reset = 1'b1;
        run(32);

        phase = "lz_0050";
        digits = 16'h0050;
        run(32);

        phase = "lz_zero";
        digits = 16'h0000;
        run(32);

        phase = "dash_00C7";
        digits = 16'h00C7;
        run(32);

        phase = "midframe_hold";
        digits = 16'h1111;
        run(24);
        digits = 16'h2222;
        run(24);

        phase = "dp_in";
        digits = 16'h1234;
        dp_in = 4'b0110;
        run(32);

        phase = "ovf_set";
        c_in = 1'b1;
        run(1);
        c_in = 1'b0;
        run(31);

        phase = "ovf_set_wins";
        c_in = 1'b1;
        clr = 1'b1;
        run(1);
        c_in = 1'b0;
        clr = 1'b0;
        run(31);

        phase = "ovf_clr";
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        run(31);

        phase = "reset_mid";
        run(10);
        chk("pre_reset_an_idx2", {16'h0, an}, {16'h0, 4'hB});
        n_reset = 1'b0;
        #1;
        mon_o = '{an: an, seg: seg, dp: dp, ft: frame_tick, seg16: seg16};
        chk("async_reset_outputs", mon_o, RST_VAL);
        run(2);
        n_reset = 1'b1;
        phase = "restart";
        @(posedge clk);
        #1;
        chk("restart_tick", {19'h0, frame_tick}, 20'h1);
        @(posedge clk);
        #1;
        chk("restart_an0", {16'h0, an}, {16'h0, 4'hE});
        run(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_digit_scanner.md
# m_digit_scanner

Time-multiplexed 7-segment display driver that consumes the 4-bit digit values and carry-out of a chain of cascaded universal counters. It captures a coherent snapshot of all digits once per scan frame, drives one common-anode digit at a time with a blanking gap between digits, suppresses leading zeros, and latches counter overflow as a sticky indication. It sits between the counter chain and the board's segment/anode pins.

## Interface
- P_DIGITS, 4: number of digits scanned (1..8); digit 0 is least significant.
- P_SCAN_DIVIDE, 1000: clk cycles per digit slot, including the blank cycle (≥2).
- P_BASE_NUMBER, 10: counter base (2..16); digit values ≥ P_BASE_NUMBER show as a dash.
- clk  in  1  system clock.
- n_reset  in  1  reset, asynchronous, active-low.
- digits  in  4*P_DIGITS  digit values; digit i at bits [4i+3:4i].
- dp_in  in  P_DIGITS  requested decimal points, 1 = lit.
- c_in  in  1  carry-out of the most significant counter; a high sample sets overflow.
- clr  in  1  synchronous clear of the overflow flag.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  P_DIGITS  digit anodes, one-hot active-low.
- frame_tick  out  1  one-cycle pulse when the snapshot is taken.

## Operation
- FSM states S_BLANK and S_SHOW. S_BLANK lasts exactly 1 cycle, then S_SHOW lasts P_SCAN_DIVIDE-1 cycles, then back to S_BLANK with index+1, wrapping P_DIGITS-1 → 0.
- Prescaler runs 0..P_SCAN_DIVIDE-1. It is 0 in S_BLANK and reaches its terminal count in the last S_SHOW cycle.
- Snapshot: on the S_BLANK cycle with index 0, digits and dp_in are registered and frame_tick=1. Digits shown during a frame never change mid-frame.
- Leading-zero blanking: digit i>0 is blank (seg=7'h7F, dp unlit unless overflow) when snapshot digit i and all higher digits are 0. Digit 0 is never blanked.
- Decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex). Any value ≥ P_BASE_NUMBER decodes to dash 3F.
- Overflow flag is sticky:
  - set when c_in=1 on any clk edge;
  - cleared by clr=1;
  - set wins when both are high.
- While the flag is set, every displayed slot lights dp, including blanked leading digits. Otherwise dp = !snapshot dp_in[index].

## Timing
- Reset values: an=all 1, seg=7'h7F, dp=1, frame_tick=0, state S_BLANK, index 0, prescaler 0, snapshot 0, overflow 0.
- All outputs are registered.
- an[index]=0 exactly during S_SHOW cycles. an is all 1 during S_BLANK.
- seg/dp change only on the edge entering S_SHOW. They hold 7'h7F/1 during S_BLANK.
- First edge after reset release: S_BLANK for index 0, snapshot taken, frame_tick=1. Second edge: an[0]=0.
- Frame length is P_DIGITS*P_SCAN_DIVIDE cycles. frame_tick is periodic with that period.
- Latency from a digits change to display is ≤ one frame plus P_SCAN_DIVIDE cycles.
- c_in → dp effect: visible from the next S_SHOW entry.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The scan restarts at index 0.

## Structure
- Package pkg_digit_scanner holds:
  - typedef enum e_scan_state {S_BLANK, S_SHOW};
  - the 16 segment constants plus SEG_DASH and SEG_OFF;
  - function f_pos for prescaler width, $clog2(P_SCAN_DIVIDE).
- Sub-module m_seg7_decoder is purely combinational: 4-bit value plus base in, 7-bit active-low segments out.
- Top level keeps the FSM, prescaler, index, snapshot, blanking and overflow logic.

## Test plan
All scenarios use P_DIGITS=4, P_SCAN_DIVIDE=4, P_BASE_NUMBER=10.
- Reset then digits=16'h1234: an cycles E,D,B,7 (one S_SHOW slot each, 3 cycles), seg=19,30,24,79, an=F on every 4th cycle, frame_tick every 16 cycles.
- digits=16'h0050: digits 3 and 2 blank (seg=7F with their an low), digit 1 seg=12, digit 0 seg=40. digits=0: only digit 0 shows 40.
- digits=16'h00C7 with base 10: digit 1 shows dash 3F. With P_BASE_NUMBER=16: digit 1 shows 46.
- Change digits from 16'h1111 to 16'h2222 at index 2 mid-frame: rest of frame still shows 79; next frame shows 24 on all digits.
- Pulse c_in for 1 cycle: dp=0 on all subsequent slots. clr and c_in high together: flag stays set. clr alone: dp follows dp_in from the next slot.
- Assert n_reset low during S_SHOW of index 2: an=F and seg=7F within the same cycle. After release, frame_tick=1 on the first edge and an=E on the second edge.
